// File: rtl/mdu_issue_arbiter_pkg.sv
// Shared definitions for the MDU issue arbiter: FSM encoding, M-op selects, default width.
// No logic; constants and types only.
// Imported by the arbiter top and its testbench.
package mdu_issue_arbiter_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/mdu_issue_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant; pointer flips to the other side after each grant.
// Latency: grant is combinational from requests and enable.
// Backpressure: no grant while i_en is low; pointer only moves when a grant is issued.
module rr_arbiter2 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_req0,
  input  logic i_req1,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic r_ptr;

  // Lone requester always wins; on contention the pointer picks the winner.
  always_comb begin
    o_gnt0 = i_en && i_req0 && (!i_req1 || !r_ptr);
    o_gnt1 = i_en && i_req1 && (!i_req0 ||  r_ptr);
  end

  // Hand priority to the side that was not just served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= RR_INIT;
    end else if (o_gnt0) begin
      r_ptr <= 1'b1;
    end else if (o_gnt1) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_issue_arbiter.sv
// Shares one multi-cycle MDU between way0/way1: one op in flight, round-robin issue.
// Latency: accept -> mdu_valid_o next cycle; result presented the cycle after the MDU pulse.
// Backpressure: ways are only granted in IDLE; MDU request held until mdu_ready_i; result held until owner's resultReady_i.
module mdu_issue_arbiter
  import mdu_issue_arbiter_pkg::*;
#(
  parameter int XLEN    = mdu_issue_arbiter_pkg::XLEN,
  parameter int RR_INIT = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            way0_valid_i,
  output logic            way0_ready_o,
  input  logic [XLEN-1:0] way0_rs1_i,
  input  logic [XLEN-1:0] way0_rs2_i,
  input  logic [2:0]      way0_funct3_i,
  input  logic            way0_word_i,
  input  logic [4:0]      way0_rdAddr_i,
  input  logic            way1_valid_i,
  output logic            way1_ready_o,
  input  logic [XLEN-1:0] way1_rs1_i,
  input  logic [XLEN-1:0] way1_rs2_i,
  input  logic [2:0]      way1_funct3_i,
  input  logic            way1_word_i,
  input  logic [4:0]      way1_rdAddr_i,
  output logic            way0_resultValid_o,
  input  logic            way0_resultReady_i,
  output logic [XLEN-1:0] way0_result_o,
  output logic [4:0]      way0_rdAddr_o,
  output logic            way1_resultValid_o,
  input  logic            way1_resultReady_i,
  output logic [XLEN-1:0] way1_result_o,
  output logic [4:0]      way1_rdAddr_o,
  output logic            mdu_valid_o,
  input  logic            mdu_ready_i,
  output logic [XLEN-1:0] mdu_rs1_o,
  output logic [XLEN-1:0] mdu_rs2_o,
  output logic [2:0]      mdu_funct3_o,
  output logic            mdu_word_o,
  input  logic            mdu_resultValid_i,
  input  logic [XLEN-1:0] mdu_result_i
);

  state_e          r_state;
  logic            r_owner;    // 0 = way0, 1 = way1
  logic            r_discard;  // in-flight op was flushed; drop its result
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [2:0]      r_funct3;
  logic            r_word;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;

  logic w_gnt_en;
  logic w_gnt0;
  logic w_gnt1;
  logic w_resp0;
  logic w_resp1;
  logic w_owner_rdy;

  assign w_gnt_en = (r_state == IDLE) && !flush_i;

  rr_arbiter2 #(
    .RR_INIT (1'(RR_INIT))
  ) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_en    (w_gnt_en),
    .i_req0  (way0_valid_i),
    .i_req1  (way1_valid_i),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1)
  );

  // Grant implies valid, so ready doubles as the accept strobe.
  always_comb begin
    way0_ready_o = w_gnt0;
    way1_ready_o = w_gnt1;
    w_resp0      = (r_state == RESP) && !r_owner;
    w_resp1      = (r_state == RESP) &&  r_owner;
    w_owner_rdy  = r_owner ? way1_resultReady_i : way0_resultReady_i;
  end

  // MDU request and per-way result ports; the non-owner way sees all zeros.
  always_comb begin
    mdu_valid_o        = (r_state == ISSUE);
    mdu_rs1_o          = r_rs1;
    mdu_rs2_o          = r_rs2;
    mdu_funct3_o       = r_funct3;
    mdu_word_o         = r_word;
    way0_resultValid_o = w_resp0 && !flush_i;
    way1_resultValid_o = w_resp1 && !flush_i;
    way0_result_o      = w_resp0 ? r_result : '0;
    way1_result_o      = w_resp1 ? r_result : '0;
    way0_rdAddr_o      = w_resp0 ? r_rd : '0;
    way1_rdAddr_o      = w_resp1 ? r_rd : '0;
  end

  // Issue FSM: latch the granted op, hold the MDU request, catch the result, return it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_discard <= 1'b0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct3  <= '0;
      r_word    <= 1'b0;
      r_rd      <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_owner   <= w_gnt1;
            r_rs1     <= w_gnt1 ? way1_rs1_i    : way0_rs1_i;
            r_rs2     <= w_gnt1 ? way1_rs2_i    : way0_rs2_i;
            r_funct3  <= w_gnt1 ? way1_funct3_i : way0_funct3_i;
            r_word    <= w_gnt1 ? way1_word_i   : way0_word_i;
            r_rd      <= w_gnt1 ? way1_rdAddr_i : way0_rdAddr_i;
            r_discard <= 1'b0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          // A request once raised is never withdrawn; a flush only marks it dead.
          if (flush_i) r_discard <= 1'b1;
          if (mdu_ready_i) r_state <= WAIT;
        end
        WAIT: begin
          if (mdu_resultValid_i) begin
            r_result <= mdu_result_i;
            if (r_discard || flush_i) begin
              r_discard <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_state   <= RESP;
            end
          end else if (flush_i) begin
            r_discard <= 1'b1;
          end
        end
        RESP: begin
          if (flush_i || w_owner_rdy) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
